ddr_act_cmd_monitor: RTL and testbench
======================================

Name: ddr_act_cmd_monitor

Overview:
- Receive side of the controller's ACTIVATE/PRECHARGE path: sits on the DDR4 command pins, decodes every issued command and tracks per-bank open/closed state and open row for 16 banks (4 bank groups x 4 banks).
- Checks bank-state legality and tRRD/tRCD/tRP spacing. Publishes a registered command event stream plus error flags to the scoreboard.
- Exposes a bank-state query port for the bench.

Parameters:
- tRRD, 4, minimum ACT-to-ACT spacing in CK cycles, any banks.
- tRCD, 16, minimum ACT-to-RD/WR spacing, same bank.
- tRP, 16, minimum PRE-to-ACT spacing, same bank.
- CNT_W, 6, width of the saturating spacing counters.

Ports:
- CK_t, in, 1, clock; all logic on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- cs_n, in, 1, chip select; 1 means deselect, nothing decoded.
- act_n, in, 1, 0 means ACT.
- ras_n_a16, in, 1, RAS_n when act_n=1.
- cas_n_a15, in, 1, CAS_n when act_n=1.
- we_n_a14, in, 1, WE_n when act_n=1; row bit 14 during ACT.
- bg, in, 2, bank group.
- ba, in, 2, bank address.
- a, in, 14, address bits; a[10] selects PRE-all.
- q_bank, in, 4, query index {bg,ba}.
- q_open, out, 1, combinational: bank q_bank is open.
- q_row, out, 15, combinational: open row of q_bank; 0 if closed.
- ev_valid, out, 1, registered command event pulse.
- ev_type, out, 3, 1=ACT, 2=PRE, 3=PREA, 4=RD, 5=WR.
- ev_bank, out, 4, {bg,ba}.
- ev_row, out, 15, {we_n_a14,a[13:0]} for ACT, else 0.
- ev_col, out, 10, a[9:0] for RD/WR, else 0.
- err_valid, out, 1, registered, one-cycle pulse.
- err_code, out, 3, 1=ACT_OPEN, 2=RW_CLOSED, 3=TRRD, 4=TRCD, 5=TRP.
- err_cnt, out, 16, saturating error count.

Behaviour:
- Decode when cs_n=0 on a rising edge:
  - act_n=0: ACT.
  - {ras,cas,we}=010: PRE (a[10]=0) or PREA (a[10]=1).
  - 101: RD.
  - 100: WR.
  - Anything else, including 111 and cs_n=1: ignored, no event.
- Latency: an event is captured at edge N; ev_* and err_* are valid after edge N (visible through cycle N+1). ev_valid is a one-cycle pulse.
- Reset (asynchronous): all banks closed, rows 0, ev_valid=0, ev_type=0, ev_bank=0, ev_row=0, ev_col=0, err_valid=0, err_code=0, err_cnt=0, every spacing counter at saturation (all ones).
- Spacing counters, one global (since last ACT) plus per bank (since ACT, since PRE):
  - Loaded with 1 at the edge capturing the relevant command.
  - Increment every later edge, saturating at 2^CNT_W-1.
  - Value sampled at a later command edge equals its distance in cycles.
- ACT:
  - Error priority: ACT_OPEN if the bank is open; else TRRD if global < tRRD; else TRP if the bank's PRE counter < tRP.
  - State always updated: bank open, row stored, counters reloaded.
- PRE closes the bank and reloads its PRE counter. PRE to a closed bank is legal: no error, counter still reloaded.
- PREA closes all 16 banks and reloads all 16 PRE counters. ev_bank=0.
- RD/WR:
  - Error priority: RW_CLOSED if the bank is closed; else TRCD if the bank's ACT counter < tRCD.
  - No state change.
- Only one error per command (highest priority). err_cnt increments by 1 per error, saturating at 16'hFFFF.
- Reset asserted mid-sequence discards all bank state. The first ACT after release reports no timing error.

Test Plan:
- Reset release; ACT bg=1 ba=2 row=0x1234 -> ev_valid=1, ev_type=1, ev_bank=6, ev_row=0x1234; q_bank=6 gives q_open=1, q_row=0x1234; err_valid=0.
- ACT bank 0 at cycle 0, ACT bank 5 at cycle 3 -> err_code=3 (TRRD), err_cnt=1, bank 5 open. Repeat with spacing 4 -> no error.
- ACT bank 2, RD bank 2 col=0x3F after 15 cycles -> ev_type=4, ev_col=0x3F, err_code=4. Same RD after 16 cycles -> no error.
- PRE bank 2, then ACT bank 2 after 10 cycles -> err_code=5. After 16 cycles -> clean, q_open=1.
- ACT banks 0, 4, 8 (legally spaced), then PREA (a[10]=1) -> ev_type=3; q_open=0 for all 16 banks. WR bank 4 -> err_code=2.
- ACT bank 1 twice, 20 cycles apart -> err_code=1, q_row holds the second row. Assert reset_n low mid-burst -> all outputs and err_cnt return to 0.

Source files
------------

// File: rtl/ddr_act_cmd_monitor_if.sv
// DDR4 command-pin bundle plus the monitor's query, event and error outputs.
interface ddr_act_cmd_monitor_if;
  logic        cs_n;
  logic        act_n;
  logic        ras_n_a16;
  logic        cas_n_a15;
  logic        we_n_a14;
  logic [1:0]  bg;
  logic [1:0]  ba;
  logic [13:0] a;

  logic [3:0]  q_bank;
  logic        q_open;
  logic [14:0] q_row;

  logic        ev_valid;
  logic [2:0]  ev_type;
  logic [3:0]  ev_bank;
  logic [14:0] ev_row;
  logic [9:0]  ev_col;

  logic        err_valid;
  logic [2:0]  err_code;
  logic [15:0] err_cnt;

  // Command driver / scoreboard side
  modport master (
    output cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg, ba, a, q_bank,
    input  q_open, q_row, ev_valid, ev_type, ev_bank, ev_row, ev_col,
    input  err_valid, err_code, err_cnt
  );

  // Monitor side
  modport slave (
    input  cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg, ba, a, q_bank,
    output q_open, q_row, ev_valid, ev_type, ev_bank, ev_row, ev_col,
    output err_valid, err_code, err_cnt
  );
endinterface

// File: rtl/ddr_act_cmd_monitor.sv
// Decodes DDR4 ACT/PRE/PREA/RD/WR commands, tracks 16 banks and checks
// bank-state legality plus tRRD/tRCD/tRP spacing.
module ddr_act_cmd_monitor #(
  parameter int unsigned TRRD  = 4,
  parameter int unsigned TRCD  = 16,
  parameter int unsigned TRP   = 16,
  parameter int unsigned CNT_W = 6
) (
  input  logic                  CK_t,
  input  logic                  reset_n,
  ddr_act_cmd_monitor_if.slave  bus
);
  localparam int unsigned NBANK = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] EV_NONE = 3'd0;
  localparam logic [2:0] EV_ACT  = 3'd1;
  localparam logic [2:0] EV_PRE  = 3'd2;
  localparam logic [2:0] EV_PREA = 3'd3;
  localparam logic [2:0] EV_RD   = 3'd4;
  localparam logic [2:0] EV_WR   = 3'd5;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_ACT_OPEN  = 3'd1;
  localparam logic [2:0] ERR_RW_CLOSED = 3'd2;
  localparam logic [2:0] ERR_TRRD      = 3'd3;
  localparam logic [2:0] ERR_TRCD      = 3'd4;
  localparam logic [2:0] ERR_TRP       = 3'd5;

  logic [NBANK-1:0] bank_open_q, bank_open_d;
  logic [14:0]      row_q     [NBANK];
  logic [14:0]      row_d     [NBANK];
  logic [CNT_W-1:0] act_cnt_q [NBANK];
  logic [CNT_W-1:0] act_cnt_d [NBANK];
  logic [CNT_W-1:0] pre_cnt_q [NBANK];
  logic [CNT_W-1:0] pre_cnt_d [NBANK];
  logic [CNT_W-1:0] rrd_cnt_q, rrd_cnt_d;

  logic        ev_valid_q, ev_valid_d;
  logic [2:0]  ev_type_q,  ev_type_d;
  logic [3:0]  ev_bank_q,  ev_bank_d;
  logic [14:0] ev_row_q,   ev_row_d;
  logic [9:0]  ev_col_q,   ev_col_d;
  logic        err_valid_q, err_valid_d;
  logic [2:0]  err_code_q,  err_code_d;
  logic [15:0] err_cnt_q,   err_cnt_d;

  logic [2:0]  cmd_type;
  logic [3:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign cmd_bank = {bus.bg, bus.ba};
  assign cmd_row  = {bus.we_n_a14, bus.a};
  assign cmd_col  = bus.a[9:0];

  // Command decode from the pin encoding; anything unrecognised is EV_NONE
  always_comb begin
    cmd_type = EV_NONE;
    if (!bus.cs_n) begin
      if (!bus.act_n) begin
        cmd_type = EV_ACT;
      end else begin
        unique case ({bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14})
          3'b010:  cmd_type = bus.a[10] ? EV_PREA : EV_PRE;
          3'b101:  cmd_type = EV_RD;
          3'b100:  cmd_type = EV_WR;
          default: cmd_type = EV_NONE;
        endcase
      end
    end
  end

  // Bank state, spacing counters, event and error next-state
  always_comb begin
    bank_open_d = bank_open_q;
    rrd_cnt_d   = sat_inc(rrd_cnt_q);
    for (int unsigned i = 0; i < NBANK; i++) begin
      row_d[i]     = row_q[i];
      act_cnt_d[i] = sat_inc(act_cnt_q[i]);
      pre_cnt_d[i] = sat_inc(pre_cnt_q[i]);
    end
    ev_valid_d = (cmd_type != EV_NONE);
    ev_type_d  = cmd_type;
    ev_bank_d  = '0;
    ev_row_d   = '0;
    ev_col_d   = '0;
    err_code_d = ERR_NONE;

    unique case (cmd_type)
      EV_ACT: begin
        if (bank_open_q[cmd_bank])                       err_code_d = ERR_ACT_OPEN;
        else if (rrd_cnt_q < CNT_W'(TRRD))               err_code_d = ERR_TRRD;
        else if (pre_cnt_q[cmd_bank] < CNT_W'(TRP))      err_code_d = ERR_TRP;
        bank_open_d[cmd_bank] = 1'b1;
        row_d[cmd_bank]       = cmd_row;
        act_cnt_d[cmd_bank]   = CNT_W'(1);
        rrd_cnt_d             = CNT_W'(1);
        ev_bank_d             = cmd_bank;
        ev_row_d              = cmd_row;
      end
      EV_PRE: begin
        bank_open_d[cmd_bank] = 1'b0;
        row_d[cmd_bank]       = '0;
        pre_cnt_d[cmd_bank]   = CNT_W'(1);
        ev_bank_d             = cmd_bank;
      end
      EV_PREA: begin
        bank_open_d = '0;
        for (int unsigned i = 0; i < NBANK; i++) begin
          row_d[i]     = '0;
          pre_cnt_d[i] = CNT_W'(1);
        end
      end
      EV_RD, EV_WR: begin
        if (!bank_open_q[cmd_bank])                      err_code_d = ERR_RW_CLOSED;
        else if (act_cnt_q[cmd_bank] < CNT_W'(TRCD))     err_code_d = ERR_TRCD;
        ev_bank_d = cmd_bank;
        ev_col_d  = cmd_col;
      end
      default: ;
    endcase

    err_valid_d = (err_code_d != ERR_NONE);
    err_cnt_d   = (err_valid_d && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  // State and output registers; counters reset to saturation so nothing looks too close
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      bank_open_q <= '0;
      rrd_cnt_q   <= CNT_MAX;
      for (int unsigned i = 0; i < NBANK; i++) begin
        row_q[i]     <= '0;
        act_cnt_q[i] <= CNT_MAX;
        pre_cnt_q[i] <= CNT_MAX;
      end
      ev_valid_q  <= 1'b0;
      ev_type_q   <= '0;
      ev_bank_q   <= '0;
      ev_row_q    <= '0;
      ev_col_q    <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      bank_open_q <= bank_open_d;
      rrd_cnt_q   <= rrd_cnt_d;
      row_q       <= row_d;
      act_cnt_q   <= act_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      ev_valid_q  <= ev_valid_d;
      ev_type_q   <= ev_type_d;
      ev_bank_q   <= ev_bank_d;
      ev_row_q    <= ev_row_d;
      ev_col_q    <= ev_col_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.q_open    = bank_open_q[bus.q_bank];
  assign bus.q_row     = bank_open_q[bus.q_bank] ? row_q[bus.q_bank] : '0;
  assign bus.ev_valid  = ev_valid_q;
  assign bus.ev_type   = ev_type_q;
  assign bus.ev_bank   = ev_bank_q;
  assign bus.ev_row    = ev_row_q;
  assign bus.ev_col    = ev_col_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_ddr_act_cmd_monitor.sv
// Bench for ddr_act_cmd_monitor: directed scenarios plus random command traffic
// checked against a cycle-stamp bank model.
module tb_ddr_act_cmd_monitor;
  localparam int K_IDLE = 0;
  localparam int K_ACT  = 1;
  localparam int K_PRE  = 2;
  localparam int K_PREA = 3;
  localparam int K_RD   = 4;
  localparam int K_WR   = 5;
  localparam int K_JUNK = 6;
  localparam int NEVER  = -1000000;
  localparam int T_RRD  = 4;
  localparam int T_RCD  = 16;
  localparam int T_RP   = 16;

  logic CK_t = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  ddr_act_cmd_monitor_if bus ();

  ddr_act_cmd_monitor dut (
    .CK_t    (CK_t),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 CK_t = ~CK_t;
  always @(posedge CK_t) cyc <= cyc + 1;

  // Reference model: open flags, rows and the cycle of each bank's last ACT/PRE
  bit          m_open [16];
  logic [14:0] m_row  [16];
  int          m_lact [16];
  int          m_lpre [16];
  int          m_lany;
  int          m_errcnt;

  bit          x_ev;
  logic [2:0]  x_type;
  logic [3:0]  x_bank;
  logic [14:0] x_row;
  logic [9:0]  x_col;
  logic [2:0]  x_err;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = '0;
      m_lact[i] = NEVER;
      m_lpre[i] = NEVER;
    end
    m_lany   = NEVER;
    m_errcnt = 0;
  endfunction

  function automatic void model_apply(input int kind, input logic [3:0] b,
                                      input logic [14:0] row, input logic [9:0] col);
    x_ev = 1'b1; x_bank = b; x_row = '0; x_col = '0; x_err = 3'd0;
    case (kind)
      K_ACT: begin
        x_type = 3'd1; x_row = row;
        if (m_open[b])                  x_err = 3'd1;
        else if (cyc - m_lany < T_RRD)  x_err = 3'd3;
        else if (cyc - m_lpre[b] < T_RP) x_err = 3'd5;
        m_open[b] = 1'b1; m_row[b] = row; m_lact[b] = cyc; m_lany = cyc;
      end
      K_PRE: begin
        x_type = 3'd2; m_open[b] = 1'b0; m_lpre[b] = cyc;
      end
      K_PREA: begin
        x_type = 3'd3; x_bank = '0;
        for (int i = 0; i < 16; i++) begin
          m_open[i] = 1'b0; m_lpre[i] = cyc;
        end
      end
      K_RD, K_WR: begin
        x_type = (kind == K_RD) ? 3'd4 : 3'd5; x_col = col;
        if (!m_open[b])                   x_err = 3'd2;
        else if (cyc - m_lact[b] < T_RCD) x_err = 3'd4;
      end
      default: begin
        x_ev = 1'b0; x_type = '0;
      end
    endcase
    if (x_err != 3'd0 && m_errcnt < 65535) m_errcnt++;
  endfunction

  task automatic drive_idle();
    bus.cs_n = 1'b1; bus.act_n = 1'b1;
    {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b111;
  endtask

  // One command on one clock edge, then compare everything against the model
  task automatic step(input int kind, input logic [3:0] b, input logic [14:0] row,
                      input logic [9:0] col, input logic [3:0] qb);
    logic [2:0] junk_tbl [5];
    junk_tbl = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b111};
    @(negedge CK_t);
    bus.cs_n = 1'b0; bus.act_n = 1'b1;
    bus.bg = b[3:2]; bus.ba = b[1:0];
    bus.a = 14'($urandom);
    bus.q_bank = qb;
    case (kind)
      K_ACT: begin
        bus.act_n = 1'b0;
        bus.ras_n_a16 = 1'($urandom); bus.cas_n_a15 = 1'($urandom);
        bus.we_n_a14 = row[14]; bus.a = row[13:0];
      end
      K_PRE:  begin {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b010; bus.a[10] = 1'b0; end
      K_PREA: begin {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b010; bus.a[10] = 1'b1; end
      K_RD:   begin {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b101; bus.a[9:0] = col; end
      K_WR:   begin {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b100; bus.a[9:0] = col; end
      K_JUNK: {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = junk_tbl[$urandom_range(0, 4)];
      default: begin
        bus.cs_n = 1'b1; bus.act_n = 1'($urandom);
        {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'($urandom);
      end
    endcase
    @(posedge CK_t);
    #1;
    model_apply(kind, b, row, col);
    drive_idle();
    check("ev_valid", 32'(bus.ev_valid), 32'(x_ev));
    if (x_ev) begin
      check("ev_type", 32'(bus.ev_type), 32'(x_type));
      check("ev_bank", 32'(bus.ev_bank), 32'(x_bank));
      check("ev_row",  32'(bus.ev_row),  32'(x_row));
      check("ev_col",  32'(bus.ev_col),  32'(x_col));
    end
    check("err_valid", 32'(bus.err_valid), 32'(x_err != 3'd0));
    if (x_err != 3'd0) check("err_code", 32'(bus.err_code), 32'(x_err));
    check("err_cnt", 32'(bus.err_cnt), 32'(m_errcnt));
    check("q_open", 32'(bus.q_open), 32'(m_open[qb]));
    check("q_row",  32'(bus.q_row),  m_open[qb] ? 32'(m_row[qb]) : 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(K_IDLE, 4'd0, 15'd0, 10'd0, 4'($urandom));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    @(negedge CK_t);
    drive_idle();
    rst_n = 1'b0;
    #1;
    check("rst_ev_valid",  32'(bus.ev_valid),  32'd0);
    check("rst_ev_type",   32'(bus.ev_type),   32'd0);
    check("rst_ev_bank",   32'(bus.ev_bank),   32'd0);
    check("rst_ev_row",    32'(bus.ev_row),    32'd0);
    check("rst_ev_col",    32'(bus.ev_col),    32'd0);
    check("rst_err_valid", 32'(bus.err_valid), 32'd0);
    check("rst_err_code",  32'(bus.err_code),  32'd0);
    check("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
    check("rst_q_open",    32'(bus.q_open),    32'd0);
    model_reset();
    repeat (2) @(negedge CK_t);
    rst_n = 1'b1;
  endtask

  task automatic check_all_closed(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.q_bank = 4'(i);
      #1;
      check(tag, 32'(bus.q_open), 32'd0);
    end
  endtask

  initial begin
    int k;
    int r;
    logic [3:0] b;
    drive_idle();
    bus.bg = '0; bus.ba = '0; bus.a = '0; bus.q_bank = '0;
    model_reset();
    do_reset();

    // Single ACT to bank 6
    step(K_ACT, 4'd6, 15'h1234, 10'd0, 4'd6);
    check("t1_type", 32'(bus.ev_type), 32'd1);
    check("t1_bank", 32'(bus.ev_bank), 32'd6);
    check("t1_row",  32'(bus.ev_row),  32'h1234);
    check("t1_qrow", 32'(bus.q_row),   32'h1234);
    check("t1_err",  32'(bus.err_valid), 32'd0);

    // tRRD: spacing 3 violates, spacing 4 is clean
    do_reset();
    step(K_ACT, 4'd0, 15'h0011, 10'd0, 4'd0);
    idle(2);
    step(K_ACT, 4'd5, 15'h0055, 10'd0, 4'd5);
    check("t2_code", 32'(bus.err_code), 32'd3);
    check("t2_cnt",  32'(bus.err_cnt),  32'd1);
    check("t2_open", 32'(bus.q_open),   32'd1);
    idle(3);
    step(K_ACT, 4'd9, 15'h0099, 10'd0, 4'd9);
    check("t2_clean", 32'(bus.err_valid), 32'd0);

    // tRCD: RD 15 cycles after ACT violates, 16 is clean
    do_reset();
    step(K_ACT, 4'd2, 15'h0222, 10'd0, 4'd2);
    idle(14);
    step(K_RD, 4'd2, 15'd0, 10'h03F, 4'd2);
    check("t3_type", 32'(bus.ev_type),  32'd4);
    check("t3_col",  32'(bus.ev_col),   32'h03F);
    check("t3_code", 32'(bus.err_code), 32'd4);
    step(K_RD, 4'd2, 15'd0, 10'h03F, 4'd2);
    check("t3_clean", 32'(bus.err_valid), 32'd0);

    // tRP: ACT 10 cycles after PRE violates, 16 is clean
    step(K_PRE, 4'd2, 15'd0, 10'd0, 4'd2);
    idle(9);
    step(K_ACT, 4'd2, 15'h0333, 10'd0, 4'd2);
    check("t4_code", 32'(bus.err_code), 32'd5);
    step(K_PRE, 4'd2, 15'd0, 10'd0, 4'd2);
    idle(15);
    step(K_ACT, 4'd2, 15'h0444, 10'd0, 4'd2);
    check("t4_clean", 32'(bus.err_valid), 32'd0);
    check("t4_open",  32'(bus.q_open),    32'd1);

    // PREA closes every bank; WR afterwards hits a closed bank
    do_reset();
    step(K_ACT, 4'd0, 15'h0100, 10'd0, 4'd0);
    idle(3);
    step(K_ACT, 4'd4, 15'h0104, 10'd0, 4'd4);
    idle(3);
    step(K_ACT, 4'd8, 15'h0108, 10'd0, 4'd8);
    step(K_PREA, 4'd7, 15'd0, 10'd0, 4'd4);
    check("t5_type", 32'(bus.ev_type), 32'd3);
    check("t5_bank", 32'(bus.ev_bank), 32'd0);
    check_all_closed("t5_closed");
    step(K_WR, 4'd4, 15'd0, 10'h155, 4'd4);
    check("t5_code", 32'(bus.err_code), 32'd2);

    // ACT to an already open bank, then reset in the middle of a burst
    do_reset();
    step(K_ACT, 4'd1, 15'h1111, 10'd0, 4'd1);
    idle(19);
    step(K_ACT, 4'd1, 15'h7ABC, 10'd0, 4'd1);
    check("t6_code", 32'(bus.err_code), 32'd1);
    check("t6_qrow", 32'(bus.q_row),    32'h7ABC);
    step(K_ACT, 4'd3, 15'h0003, 10'd0, 4'd3);
    do_reset();
    check_all_closed("t6_closed");
    step(K_ACT, 4'd3, 15'h0005, 10'd0, 4'd3);
    check("t6_first_act", 32'(bus.err_valid), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if      (r < 25) k = K_IDLE;
      else if (r < 50) k = K_ACT;
      else if (r < 65) k = K_PRE;
      else if (r < 68) k = K_PREA;
      else if (r < 80) k = K_RD;
      else if (r < 92) k = K_WR;
      else             k = K_JUNK;
      b = 4'($urandom);
      step(k, b, 15'($urandom), 10'($urandom), ($urandom_range(0, 1) == 0) ? b : 4'($urandom));
      if (n == 700) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
